// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, data width and grant-index width helper for the uart tx arbiter
package uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_ACK = 2'd1, WAIT_DONE = 2'd2} state_t;
  localparam int UART_DATA_W = 8;
  function automatic int gid_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit at or above ptr with wrap
module rr_pick import uart_pkg::*; #(
  parameter int N = 4,
  localparam int W = gid_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);
  int d, best;
  assign any = |req;
  always_comb begin
    idx = '0;
    best = N;
    d = 0;
    for (int j = 0; j < N; j++) begin
      d = (j - int'(ptr) + N) % N;
      if (req[j] && d < best) begin
        best = d;
        idx = W'(j);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_tx among NUM_REQ byte sources; UART_TX_ARBITER_LOCK_EN adds grant locking
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_lock,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [UART_DATA_W-1:0]         tx_data,
  input  logic                           tx_busy,
  output logic [gid_w(NUM_REQ)-1:0]      grant_id,
  output logic                           arb_busy,
  output logic                           tx_err
);
  localparam int GW = gid_w(NUM_REQ);
  localparam int CW = gid_w(ACK_TIMEOUT);
  state_t state, nxt;
  logic [GW-1:0] rr_ptr, pick, inc_ptr, nxt_ptr;
  logic [CW-1:0] cnt;
  logic any, grant, timeout, done;
  rr_pick #(.N(NUM_REQ)) u_pick (.req(req_valid), .ptr(rr_ptr), .any(any), .idx(pick));
  assign arb_busy = state != IDLE;
  assign inc_ptr = grant_id == GW'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;
  always_comb begin
    grant = state == IDLE && !tx_busy && any;
    timeout = state == WAIT_ACK && !tx_busy && cnt == CW'(ACK_TIMEOUT - 1);
    done = state == WAIT_DONE && !tx_busy;
    nxt = grant ? WAIT_ACK : (timeout || done) ? IDLE : (state == WAIT_ACK && tx_busy) ? WAIT_DONE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx_start <= 1'b0;
      tx_data <= '0;
      req_ready <= '0;
      grant_id <= '0;
      tx_err <= 1'b0;
      rr_ptr <= '0;
      cnt <= '0;
    end else begin
      state <= nxt;
      tx_start <= grant;
      req_ready <= grant ? NUM_REQ'(1) << pick : '0;
      tx_err <= timeout;
      cnt <= state == WAIT_ACK ? cnt + 1'b1 : '0;
      if (grant) begin
        tx_data <= req_data[pick*UART_DATA_W +: UART_DATA_W];
        grant_id <= pick;
      end
      if (timeout || done) rr_ptr <= nxt_ptr;
    end
  end
`ifdef UART_TX_ARBITER_LOCK_EN
  localparam int LW = gid_w(LOCK_MAX);
  logic locked, hold;
  logic [LW-1:0] lock_cnt;
  assign hold = done && locked && lock_cnt != LW'(LOCK_MAX - 1);
  assign nxt_ptr = hold ? grant_id : inc_ptr;
  always_ff @(posedge clk) begin
    if (rst) begin
      locked <= 1'b0;
      lock_cnt <= '0;
    end else begin
      if (grant) begin
        locked <= req_lock[pick];
        if (pick != grant_id) lock_cnt <= '0;
      end
      if (timeout || done) lock_cnt <= hold ? lock_cnt + 1'b1 : '0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock ^ (LOCK_MAX > 0);
  assign nxt_ptr = inc_ptr;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed table, corner sequences and randomized model check of uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int N = 4;
  typedef struct {
    logic [N-1:0]   valid;
    logic [8*N-1:0] data;
    int             flen;
    int             exp_id;
    logic [7:0]     exp_data;
  } vec_t;
  logic clk = 0, rst = 1, tx_busy = 0;
  logic [N-1:0] req_valid = '0, req_lock = '0, req_ready;
  logic [8*N-1:0] req_data = '0;
  logic tx_start, arb_busy, tx_err;
  logic [7:0] tx_data;
  logic [1:0] grant_id;
  int n_cmp = 0, n_bad = 0;
  bit stub_en = 1, sbusy = 0, pend = 0, inflight = 0, ext_busy = 0;
  int frame_len = 5, left = 0;
  int seq[16];
  int nseq = 0;
  vec_t tbl[8];
`ifdef UART_TX_ARBITER_LOCK_EN
  int lock_exp[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 3};
`else
  int lock_exp[9] = '{1, 3, 1, 3, 1, 3, 1, 3, 1};
`endif

  uart_tx_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_lock(req_lock),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .arb_busy(arb_busy), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (sbusy) begin
      left--;
      if (left == 0) begin
        sbusy = 0;
        inflight = 0;
      end
    end
    if (pend) begin
      sbusy = 1;
      left = frame_len;
      pend = 0;
    end
    if (tx_start) begin
      check("start_while_frame", inflight, 0);
      if (stub_en) begin
        pend = 1;
        inflight = 1;
      end
    end
    tx_busy = sbusy | ext_busy;
  endtask

  task automatic do_reset();
    rst = 1;
    req_valid = '0;
    req_lock = '0;
    ext_busy = 0;
    stub_en = 1;
    sbusy = 0;
    pend = 0;
    inflight = 0;
    tx_busy = 0;
    frame_len = 5;
    tick();
    rst = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((arb_busy || tx_busy) && n < 500) begin
      tick();
      n++;
    end
    check("wait_idle", {arb_busy, tx_busy}, 0);
  endtask

  task automatic collect(input int want);
    int b = 0;
    nseq = 0;
    while (nseq < want && b < 3000) begin
      tick();
      b++;
      if (tx_start) begin
        seq[nseq] = int'(grant_id);
        nseq++;
      end
    end
    check("collect_count", nseq, want);
  endtask

  task automatic run_grant(input vec_t v);
    int n = 0, starts = 0;
    req_valid = v.valid;
    req_data = v.data;
    frame_len = v.flen;
    tick();
    check("tbl_start", tx_start, 1);
    check("tbl_ready", req_ready, 32'(1) << v.exp_id);
    check("tbl_grant", grant_id, v.exp_id);
    check("tbl_data", tx_data, v.exp_data);
    req_valid = '0;
    do begin
      tick();
      n++;
      starts += int'(tx_start);
      if (n == 2) check("tbl_busy_mid", arb_busy, 1);
    end while (arb_busy && n < 400);
    check("tbl_extra_start", starts, 0);
    check("tbl_frame_len", n, v.flen + 2);
    check("tbl_data_held", tx_data, v.exp_data);
  endtask

  initial begin
    int n, starts, mptr, grants, w;
    tbl[0] = '{4'b0100, 32'h33A52211, 160, 2, 8'hA5};
    tbl[1] = '{4'b0011, 32'h44332211, 5, 0, 8'h11};
    tbl[2] = '{4'b1001, 32'h8C7B6A59, 5, 3, 8'h8C};
    tbl[3] = '{4'b1110, 32'hF0E0D0C0, 5, 1, 8'hD0};
    tbl[4] = '{4'b0010, 32'h0F1E2D3C, 5, 1, 8'h2D};
    tbl[5] = '{4'b1111, 32'hDEADBEEF, 5, 2, 8'hAD};
    tbl[6] = '{4'b0001, 32'h12345678, 5, 0, 8'h78};
    tbl[7] = '{4'b1101, 32'hCAFEF00D, 5, 2, 8'hFE};

    rst = 1;
    req_valid = '1;
    req_data = 32'h44332211;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outputs", {tx_start, tx_data, req_ready, grant_id, arb_busy, tx_err}, 0);
    end
    rst = 0;
    tick();
    check("first_start", tx_start, 1);
    check("first_grant", grant_id, 0);
    check("first_ready", req_ready, 4'b0001);
    check("first_data", tx_data, 8'h11);
    req_valid = '0;
    wait_idle();

    do_reset();
    for (int e = 0; e < 8; e++) run_grant(tbl[e]);

    req_valid = 4'b0001;
    req_data = 32'h0000005A;
    ext_busy = 1;
    tx_busy = 1;
    starts = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      starts += int'(tx_start);
    end
    check("ext_busy_hold", starts, 0);
    ext_busy = 0;
    tx_busy = sbusy;
    tick();
    check("ext_release_start", tx_start, 1);
    check("ext_release_grant", grant_id, 0);
    req_valid = '0;
    wait_idle();

    do_reset();
    req_valid = '1;
    req_data = 32'h44332211;
    collect(5);
    for (int i = 0; i < 5; i++) check("rr_order", seq[i], i % 4);
    req_valid = '0;
    wait_idle();

    do_reset();
    stub_en = 0;
    req_valid = 4'b0010;
    tick();
    check("to_start", tx_start, 1);
    check("to_grant", grant_id, 1);
    req_valid = '0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!tx_err && n < 40);
    check("to_delay", n, 16);
    check("to_idle", arb_busy, 0);
    tick();
    check("to_pulse", tx_err, 0);
    stub_en = 1;
    req_valid = '1;
    tick();
    check("to_next_start", tx_start, 1);
    check("to_next_grant", grant_id, 2);
    req_valid = '0;
    wait_idle();

    do_reset();
    req_valid = 4'b0100;
    tick();
    check("mid_g2", grant_id, 2);
    req_valid = '0;
    wait_idle();
    frame_len = 30;
    req_valid = 4'b1000;
    tick();
    check("mid_g3", grant_id, 3);
    req_valid = '0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_busy", arb_busy, 1);
    rst = 1;
    tick();
    rst = 0;
    check("mid_reset_outputs", {tx_start, tx_data, req_ready, grant_id, arb_busy, tx_err}, 0);
    req_valid = '1;
    frame_len = 5;
    collect(1);
    check("mid_ptr_zero", seq[0], 0);
    req_valid = '0;
    wait_idle();

    do_reset();
    req_lock = 4'b0010;
    req_valid = 4'b1010;
    collect(9);
    for (int i = 0; i < 9; i++) check("lock_seq", seq[i], lock_exp[i]);
    req_valid = '0;
    req_lock = '0;
    wait_idle();

    do_reset();
    mptr = 0;
    grants = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (tx_start) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req_valid[(mptr + k) % N]) w = (mptr + k) % N;
        check("rnd_grant", grant_id, w);
        if (w >= 0) begin
          check("rnd_ready", req_ready, 32'(1) << w);
          check("rnd_data", tx_data, req_data[8*w +: 8]);
          mptr = (w + 1) % N;
        end
        grants++;
        frame_len = $urandom_range(1, 12);
      end
      if (tx_err) check("rnd_err", tx_err, 0);
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) req_valid[i] = 0;
        else if (!req_valid[i] && $urandom_range(0, 5) == 0) begin
          req_valid[i] = 1;
          req_data[8*i +: 8] = 8'($urandom);
        end
      end
    end
    check("rnd_progress", grants > 40, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
